// File: rtl/io_map_pkg.sv
// rtl/io_map_pkg.sv - IO map constants, status bit positions and UART state encoding
package io_map_pkg;

    localparam int IO_SEL_BIT = 22;

    localparam logic [3:0] IDX_LED    = 4'd0;
    localparam logic [3:0] IDX_TXDATA = 4'd1;
    localparam logic [3:0] IDX_STATUS = 4'd2;
    localparam logic [3:0] IDX_TIMER  = 4'd3;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 8;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/io_responder_if.sv
// rtl/io_responder_if.sv - CPU IO bus bundle (address, write strobe, data in/out)
interface io_responder_if;

    logic [31:0] IO_mem_addr;
    logic [31:0] IO_mem_wdata;
    logic        IO_mem_wr;
    logic [31:0] IO_mem_rdata;

    modport master (
        output IO_mem_addr,
        output IO_mem_wdata,
        output IO_mem_wr,
        input  IO_mem_rdata
    );

    modport slave (
        input  IO_mem_addr,
        input  IO_mem_wdata,
        input  IO_mem_wr,
        output IO_mem_rdata
    );

endinterface

// File: rtl/io_responder_fifo.sv
// rtl/io_responder_fifo.sv - parameterised synchronous FIFO with occupancy count
module io_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rptr];

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; only entries between the pointers are ever read
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= push_data;
    end

endmodule

// File: rtl/io_responder.sv
// rtl/io_responder.sv - IO slave with LED register, cycle timer and FIFO-buffered 8N1 UART TX
module io_responder
    import io_map_pkg::*;
#(
    parameter int BAUD_DIV   = 104,
    parameter int FIFO_DEPTH = 8,
    parameter int LED_W      = 5
) (
    input  logic             clk,
    input  logic             resetn,
    io_responder_if.slave    bus,
    output logic [LED_W-1:0] leds,
    output logic             uart_tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    logic          sel;
    logic [3:0]    idx;
    logic          we;
    logic          push_req;
    logic          ovf_clr;
    logic          overflow;
    logic [31:0]   timer;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_head;
    logic          fifo_pop;
    uart_state_t   state;
    uart_state_t   state_next;
    logic [BW-1:0] baud_cnt;
    logic          baud_done;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          busy;
    logic          unused_bits;

    assign sel         = bus.IO_mem_addr[IO_SEL_BIT];
    assign idx         = bus.IO_mem_addr[5:2];
    assign we          = bus.IO_mem_wr & sel;
    assign push_req    = we && (idx == IDX_TXDATA);
    assign ovf_clr     = we && (idx == IDX_STATUS) && bus.IO_mem_wdata[ST_OVF];
    assign baud_done   = (baud_cnt == '0);
    assign busy        = !fifo_empty || (state != UART_IDLE);
    assign unused_bits = ^{bus.IO_mem_addr, bus.IO_mem_wdata};

    io_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push_req),
        .push_data (bus.IO_mem_wdata[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // LED register load
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                   leds <= '0;
        else if (we && idx == IDX_LED) leds <= bus.IO_mem_wdata[LED_W-1:0];
    end

    // Free-running cycle timer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) timer <= '0;
        else         timer <= timer + 32'd1;
    end

    // Sticky overflow; a dropped push wins over a simultaneous clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                     overflow <= 1'b0;
        else if (push_req && fifo_full)  overflow <= 1'b1;
        else if (ovf_clr)                overflow <= 1'b0;
    end

    // Combinational read mux; the core samples in the address cycle
    always_comb begin
        bus.IO_mem_rdata = '0;
        if (sel) begin
            case (idx)
                IDX_LED:    bus.IO_mem_rdata = 32'(leds);
                IDX_STATUS: begin
                    bus.IO_mem_rdata[ST_BUSY]                 = busy;
                    bus.IO_mem_rdata[ST_FULL]                 = fifo_full;
                    bus.IO_mem_rdata[ST_OVF]                  = overflow;
                    bus.IO_mem_rdata[ST_CNT_LSB +: 8]         = 8'(fifo_count);
                end
                IDX_TIMER:  bus.IO_mem_rdata = timer;
                default:    bus.IO_mem_rdata = '0;
            endcase
        end
    end

    // UART state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= UART_IDLE;
        else         state <= state_next;
    end

    // UART next-state: each bit period ends when baud_cnt reaches zero
    always_comb begin
        state_next = state;
        case (state)
            UART_IDLE:  if (!fifo_empty) state_next = UART_START;
            UART_START: if (baud_done) state_next = UART_DATA;
            UART_DATA:  if (baud_done && bit_cnt == 3'd7) state_next = UART_STOP;
            UART_STOP:  if (baud_done) state_next = fifo_empty ? UART_IDLE : UART_START;
            default:    state_next = UART_IDLE;
        endcase
    end

    // UART outputs: pop the FIFO when a new frame begins (from idle or straight after a stop bit)
    always_comb begin
        fifo_pop = 1'b0;
        if (!fifo_empty) begin
            if (state == UART_IDLE)                   fifo_pop = 1'b1;
            else if (state == UART_STOP && baud_done) fifo_pop = 1'b1;
        end
    end

    // UART datapath: bit timer, shift register and registered line
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            uart_tx  <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else if (fifo_pop) begin
            shift    <= fifo_head;
            uart_tx  <= 1'b0;
            baud_cnt <= BAUD_LAST;
        end else if (state != UART_IDLE) begin
            if (baud_done) begin
                baud_cnt <= BAUD_LAST;
                case (state)
                    UART_START: begin
                        uart_tx <= shift[0];
                        bit_cnt <= '0;
                    end
                    UART_DATA: begin
                        shift <= shift >> 1;
                        if (bit_cnt == 3'd7) begin
                            uart_tx <= 1'b1;
                        end else begin
                            uart_tx <= shift[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    default: uart_tx <= 1'b1;
                endcase
            end else begin
                baud_cnt <= baud_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_io_responder.sv
// tb/tb_io_responder.sv - randomized self-checking bench for io_responder
module tb_io_responder;

    localparam int BAUD  = 4;
    localparam int DEPTH = 8;
    localparam int LW    = 5;

    localparam logic [31:0] A_LED    = 32'h0040_0000;
    localparam logic [31:0] A_TX     = 32'h0040_0004;
    localparam logic [31:0] A_STATUS = 32'h0040_0008;
    localparam logic [31:0] A_TIMER  = 32'h0040_000C;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [LW-1:0] leds;
    logic          uart_tx;

    io_responder_if bus();

    io_responder #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH), .LED_W(LW)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .bus     (bus.slave),
        .leds    (leds),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: byte queue plus "position within current frame"
    logic [7:0]  m_q[$];
    bit          m_in_frame;
    int          m_ft;
    logic [7:0]  m_cur;
    logic [LW-1:0] m_led;
    bit          m_ovf;
    logic [31:0] m_tmr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_in_frame = 0;
        m_ft = 0;
        m_cur = '0;
        m_led = '0;
        m_ovf = 0;
        m_tmr = '0;
    endtask

    function automatic logic model_line();
        int bi;
        if (!m_in_frame) return 1'b1;
        bi = m_ft / BAUD;
        if (bi == 0) return 1'b0;
        if (bi >= 9) return 1'b1;
        return m_cur[bi-1];
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] r;
        int n;
        r = '0;
        n = m_q.size();
        if (a[22]) begin
            case (a[5:2])
                4'd0: r = 32'(m_led);
                4'd2: r = {16'h0, 8'(n), 5'h0, m_ovf, (n == DEPTH), (n != 0 || m_in_frame)};
                4'd3: r = m_tmr;
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    task automatic model_step(input logic [31:0] a, input logic w, input logic [31:0] d);
        int pre;
        bit do_pop;
        pre = m_q.size();
        do_pop = 0;
        if (!m_in_frame) begin
            if (pre > 0) do_pop = 1;
        end else if (m_ft == 10*BAUD - 1) begin
            if (pre > 0) do_pop = 1;
            else m_in_frame = 0;
        end else begin
            m_ft++;
        end
        if (do_pop) begin
            m_cur = m_q.pop_front();
            m_in_frame = 1;
            m_ft = 0;
        end
        if (w && a[22]) begin
            case (a[5:2])
                4'd0: m_led = d[LW-1:0];
                4'd1: if (pre == DEPTH) m_ovf = 1; else m_q.push_back(d[7:0]);
                4'd2: if (d[2]) m_ovf = 0;
                default: ;
            endcase
        end
        m_tmr = m_tmr + 32'd1;
    endtask

    // One bus cycle: present inputs, check pre-edge outputs, advance DUT and model
    task automatic step(input logic [31:0] a, input logic w, input logic [31:0] d);
        bus.IO_mem_addr  = a;
        bus.IO_mem_wr    = w;
        bus.IO_mem_wdata = d;
        #1;
        chk("rdata", bus.IO_mem_rdata, model_read(a));
        chk("uart_tx", 32'(uart_tx), 32'(model_line()));
        chk("leds", 32'(leds), 32'(m_led));
        @(posedge clk);
        model_step(a, w, d);
        @(negedge clk);
    endtask

    task automatic idle_steps(input int n, input logic [31:0] a);
        for (int i = 0; i < n; i++) step(a, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [3:0]  ridx;

        bus.IO_mem_addr  = '0;
        bus.IO_mem_wr    = 1'b0;
        bus.IO_mem_wdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.IO_mem_addr = A_STATUS;
        #1;
        chk("rst_leds", 32'(leds), 32'h0);
        chk("rst_uart", 32'(uart_tx), 32'h1);
        chk("rst_status", bus.IO_mem_rdata, 32'h0);
        resetn = 1'b1;

        // Idle: status zero, timer counting
        idle_steps(3, A_STATUS);
        idle_steps(6, A_TIMER);

        // LED write, read back, unselected write ignored
        step(A_LED, 1'b1, 32'h15);
        step(A_LED, 1'b0, 32'h0);
        step(32'h0000_0000, 1'b1, 32'h0A);
        step(A_LED, 1'b0, 32'h0);

        // Single frame 0xA5
        step(A_TX, 1'b1, 32'hA5);
        idle_steps(46, A_STATUS);

        // Back-to-back frames
        step(A_TX, 1'b1, 32'h41);
        step(A_TX, 1'b1, 32'h42);
        idle_steps(90, A_STATUS);

        // Overflow: 10 pushes, clear, re-overflow, drain
        for (int i = 0; i < 10; i++) step(A_TX, 1'b1, 32'($urandom_range(0, 255)));
        idle_steps(3, A_STATUS);
        step(A_STATUS, 1'b1, 32'h4);
        idle_steps(2, A_STATUS);
        step(A_TX, 1'b1, 32'h77);
        idle_steps(2, A_STATUS);
        step(A_STATUS, 1'b1, 32'hFFFF_FFFB);
        idle_steps(2, A_STATUS);
        step(A_STATUS, 1'b1, 32'h4);
        idle_steps(380, A_STATUS);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            ridx = 4'($urandom_range(0, 5));
            ra = 32'h0;
            ra[22] = ($urandom_range(0, 3) != 0);
            ra[5:2] = ridx;
            ra[1:0] = 2'($urandom);
            ra[31:23] = 9'($urandom);
            ra[15:6] = 10'($urandom);
            step(ra, ($urandom_range(0, 9) < 2), $urandom);
        end
        idle_steps(400, A_STATUS);

        // Reset in the middle of a frame's data bits
        step(A_TX, 1'b1, 32'h5A);
        idle_steps(14, A_STATUS);
        #3;
        resetn = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_uart", 32'(uart_tx), 32'h1);
        chk("mid_rst_status", bus.IO_mem_rdata, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        idle_steps(60, A_STATUS);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_responder.md
Name: io_responder

Overview:
- Memory-mapped IO slave on the CPU's IO bus: decodes IO_mem_addr/IO_mem_wr/IO_mem_wdata and returns IO_mem_rdata.
- Hosts an LED register, a free-running cycle timer, and a FIFO-buffered 8N1 UART transmitter.
- Sits beside the core's data RAM. The core selects it when address bit 22 is set.
- Reads are combinational because the core samples IO_mem_rdata in the same cycle it presents the address. Writes are single-cycle strobes.

Parameters:
BAUD_DIV, 104, clock cycles per UART bit (12 MHz / 115200); legal range >= 2
FIFO_DEPTH, 8, TX FIFO entries; power of two, >= 2
LED_W, 5, width of LED register and leds output

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
IO_mem_addr  input  32  byte address from core; bit 22 = IO select, bits [5:2] = register index
IO_mem_wdata  input  32  write data
IO_mem_wr  input  1  write strobe, one cycle per store
IO_mem_rdata  output  32  read data, combinational
leds  output  LED_W  LED register contents
uart_tx  output  1  serial line, idle high, registered

Behaviour:
Reset:
- Async on resetn low: leds=0, uart_tx=1, FIFO empty, overflow=0, timer=0, UART state IDLE, baud counter 0.
- Reset mid-frame aborts the frame immediately; the line returns high.

Address decode:
- sel = IO_mem_addr[22]; idx = IO_mem_addr[5:2]. Other address bits are ignored.
- idx 0 LED: R/W. A write loads wdata[LED_W-1:0]. A read returns the value zero-extended.
- idx 1 TXDATA: W pushes wdata[7:0]. R returns 0.
- idx 2 STATUS: R returns:
  - bit0 busy (FIFO non-empty or state != IDLE)
  - bit1 full
  - bit2 overflow (sticky)
  - bits[15:8] FIFO count
  - all other bits 0
- STATUS write: wdata[2]=1 clears overflow (W1C). Other bits are ignored.
- idx 3 TIMER: R returns the 32-bit cycle counter, which increments every cycle and wraps 0xFFFFFFFF -> 0. Writes are ignored.
- Unmapped idx or sel=0: reads return 0 and writes have no effect.
- Register effects happen only when IO_mem_wr & sel.

TX FIFO:
- Push when write to idx 1 and count != FIFO_DEPTH.
- Full is judged on the pre-edge count: a push while full is dropped and sets overflow, even if a pop occurs in the same cycle.
- Push and pop in the same cycle on a non-full, non-empty FIFO leaves count unchanged.
- Pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
- Overflow set and W1C clear in the same cycle: set wins.

UART FSM (IDLE, START, DATA, STOP):
- IDLE, FIFO non-empty:
  - pop head into shift register
  - uart_tx<=0, baud_cnt<=BAUD_DIV-1, state START
- Each state holds for BAUD_DIV cycles. baud_cnt decrements; the action fires when baud_cnt==0.
- START end: uart_tx<=shift[0], bit_cnt<=0, state DATA.
- DATA end: shift right. If bit_cnt==7, uart_tx<=1 and state STOP; else uart_tx<=next bit and bit_cnt+1. Data is sent LSB first.
- STOP end:
  - if FIFO non-empty: pop and go directly to START (uart_tx<=0), no idle gap
  - else: state IDLE
- A write into an empty FIFO at edge E0 produces the start bit at edge E1.
- Frame length is exactly 10*BAUD_DIV cycles.

Decomposition:
- Shared package io_map_pkg holds:
  - IO_SEL_BIT=22
  - register index constants IDX_LED=0, IDX_TXDATA=1, IDX_STATUS=2, IDX_TIMER=3
  - status bit positions
  - UART state encoding (2-bit enum)
- Sub-module io_sync_fifo: parameterised width/depth synchronous FIFO with push/pop/full/empty/count and async active-low reset.
- Decode, registers and UART FSM stay in io_responder.

Test Plan:
- Reset then idle (BAUD_DIV=4): leds=0, uart_tx=1, a read of 0x400008 returns 0, and a read of 0x40000C is nonzero and increasing by 1 per cycle.
- Write 0x15 to 0x400000 -> leds=5'h15 next cycle and a read returns 0x15. Write with addr bit22=0 -> leds unchanged.
- Write 0xA5 to 0x400004 -> start bit at E1, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then a stop bit. Line high at E1+40. busy=1 during the frame, 0 after.
- Write 0x41 then 0x42 on consecutive cycles -> two frames back-to-back, the second start bit exactly 40 cycles after the first. STATUS count reads 1 while the first frame is sending.
- Push 10 bytes in consecutive cycles with FIFO_DEPTH=8 while UART idle:
  - the first byte is popped at E1, so the 10th push is dropped
  - overflow=1 and full=1 in STATUS
  - writing 0x4 to 0x400008 clears overflow; a same-cycle overflowing push keeps it set
- Assert resetn low mid-DATA of a frame -> uart_tx=1 immediately (async), FIFO count 0, no further frame after release.
